// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core pipeline: widths, control-bundle field offsets,
// exception codes and the exception handler entry point.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int TNEW_W = 2;
  localparam int REG_W  = 5;
  localparam int EXC_W  = 5;

  localparam logic [31:0] HANDLER_PC = 32'h4180;

  // Control bundle layout (bit offsets into id_ctrl / ex_ctrl)
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_ALU_SRC   = 3;
  localparam int CTRL_ALU_OP    = 4;   // 4 bits: [7:4]
  localparam int CTRL_MDU_OP    = 8;   // 4 bits: [11:8]
  localparam int CTRL_WB_SEL    = 12;  // 2 bits: [13:12]
  localparam int CTRL_LINK      = 14;
  localparam int CTRL_ERET      = 15;

  localparam logic [EXC_W-1:0] EXC_NONE    = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  // One pipeline stage closer to the result; saturates at zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID->EX stage bundle: id_* fields driven by decode, ex_* fields presented to execute.
interface id_ex_reg_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  // No valid/ready pair: the stage always advances unless hold/bubble/req say
  // otherwise, and ex_* are registered copies that change only on a clock edge.
  logic [31:0]        id_pc;
  logic [31:0]        id_instr;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_a3;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [DATA_W-1:0]  id_imm;
  logic [CTRL_W-1:0]  id_ctrl;
  logic [TNEW_W-1:0]  id_tnew;
  logic               id_bd;
  logic [EXC_W-1:0]   id_exc;

  logic [31:0]        ex_pc;
  logic [31:0]        ex_instr;
  logic [REG_W-1:0]   ex_rs;
  logic [REG_W-1:0]   ex_rt;
  logic [REG_W-1:0]   ex_a3;
  logic [DATA_W-1:0]  ex_rs_data;
  logic [DATA_W-1:0]  ex_rt_data;
  logic [DATA_W-1:0]  ex_imm;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic [TNEW_W-1:0]  ex_tnew;
  logic               ex_bd;
  logic [EXC_W-1:0]   ex_exc;

  modport master (
    output id_pc, id_instr, id_rs, id_rt, id_a3, id_rs_data, id_rt_data,
           id_imm, id_ctrl, id_tnew, id_bd, id_exc,
    input  ex_pc, ex_instr, ex_rs, ex_rt, ex_a3, ex_rs_data, ex_rt_data,
           ex_imm, ex_ctrl, ex_tnew, ex_bd, ex_exc
  );

  modport slave (
    input  id_pc, id_instr, id_rs, id_rt, id_a3, id_rs_data, id_rt_data,
           id_imm, id_ctrl, id_tnew, id_bd, id_exc,
    output ex_pc, ex_instr, ex_rs, ex_rt, ex_a3, ex_rs_data, ex_rt_data,
           ex_imm, ex_ctrl, ex_tnew, ex_bd, ex_exc
  );

endinterface

// File: rtl/id_ex_reg_operand_snoop.sv
// Next value of a held operand: takes the WB write data when WB targets the
// operand's register, otherwise keeps what is stored.
module operand_snoop
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [REG_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_data,
  input  logic [REG_W-1:0]  i_wb_a3,
  input  logic [DATA_W-1:0] i_wb_wd,
  input  logic              i_hold,
  output logic [DATA_W-1:0] o_next
);

  logic w_hit;

  // $zero is never written, so a zero WB address never counts as a hit.
  assign w_hit  = i_hold && (i_wb_a3 != '0) && (i_wb_a3 == i_idx);
  assign o_next = w_hit ? i_wb_wd : i_data;

endmodule

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with flush, hold (with WB operand snoop) and bubble insert.
module id_ex_reg
  import mips_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          CTRL_W  = 16,
  parameter logic [31:0] HANDLER = HANDLER_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             bubble,
  input  logic             req,
  input  logic [REG_W-1:0] wb_a3,
  input  logic [31:0]      wb_wd,
  id_ex_reg_if.slave       bus
);

  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_a3;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [TNEW_W-1:0] r_tnew;
  logic              r_bd;
  logic [EXC_W-1:0]  r_exc;

  logic [DATA_W-1:0] w_rs_next;
  logic [DATA_W-1:0] w_rt_next;

  operand_snoop #(.DATA_W(DATA_W)) u_snoop_rs (
    .i_idx   (r_rs),
    .i_data  (r_rs_data),
    .i_wb_a3 (wb_a3),
    .i_wb_wd (wb_wd[DATA_W-1:0]),
    .i_hold  (hold),
    .o_next  (w_rs_next)
  );

  operand_snoop #(.DATA_W(DATA_W)) u_snoop_rt (
    .i_idx   (r_rt),
    .i_data  (r_rt_data),
    .i_wb_a3 (wb_a3),
    .i_wb_wd (wb_wd[DATA_W-1:0]),
    .i_hold  (hold),
    .o_next  (w_rt_next)
  );

  always_ff @(posedge clk) begin
    if (!reset || req) begin
      r_pc      <= reset ? HANDLER : 32'h0;
      r_instr   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_a3      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_ctrl    <= '0;
      r_tnew    <= '0;
      r_bd      <= 1'b0;
      r_exc     <= EXC_NONE;
    end else if (hold) begin
      // Only the operands move while held; Tnew is deliberately frozen.
      r_rs_data <= w_rs_next;
      r_rt_data <= w_rt_next;
    end else if (bubble) begin
      // PC and BD survive so EPC/BD stay right for the stalled instruction.
      r_pc      <= bus.id_pc;
      r_instr   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_a3      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_ctrl    <= '0;
      r_tnew    <= '0;
      r_bd      <= bus.id_bd;
      r_exc     <= EXC_NONE;
    end else begin
      r_pc      <= bus.id_pc;
      r_instr   <= bus.id_instr;
      r_rs      <= bus.id_rs;
      r_rt      <= bus.id_rt;
      r_a3      <= bus.id_a3;
      r_rs_data <= bus.id_rs_data;
      r_rt_data <= bus.id_rt_data;
      r_imm     <= bus.id_imm;
      r_ctrl    <= bus.id_ctrl;
      r_tnew    <= tnew_dec(bus.id_tnew);
      r_bd      <= bus.id_bd;
      r_exc     <= bus.id_exc;
    end
  end

  assign bus.ex_pc      = r_pc;
  assign bus.ex_instr   = r_instr;
  assign bus.ex_rs      = r_rs;
  assign bus.ex_rt      = r_rt;
  assign bus.ex_a3      = r_a3;
  assign bus.ex_rs_data = r_rs_data;
  assign bus.ex_rt_data = r_rt_data;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_ctrl    = r_ctrl;
  assign bus.ex_tnew    = r_tnew;
  assign bus.ex_bd      = r_bd;
  assign bus.ex_exc     = r_exc;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios with literal expectations plus random
// traffic scored every cycle against a rule-level model of the stage.
module tb_id_ex_reg;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  a3;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [1:0]  tnew;
    logic        bd;
    logic [4:0]  exc;
  } ex_t;

  localparam int W = $bits(ex_t);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        bubble = 1'b0;
  logic        req = 1'b0;
  logic [4:0]  wb_a3 = '0;
  logic [31:0] wb_wd = '0;

  always #5 clk = ~clk;

  id_ex_reg_if #(.DATA_W(32), .CTRL_W(16)) bus ();

  id_ex_reg dut (
    .clk    (clk),
    .reset  (reset),
    .hold   (hold),
    .bubble (bubble),
    .req    (req),
    .wb_a3  (wb_a3),
    .wb_wd  (wb_wd),
    .bus    (bus)
  );

  ex_t dut_v;
  assign dut_v = {bus.ex_pc, bus.ex_instr, bus.ex_rs, bus.ex_rt, bus.ex_a3,
                  bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_ctrl,
                  bus.ex_tnew, bus.ex_bd, bus.ex_exc};

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  ex_t m = '0;

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    ex_t n;
    n = m;
    if (!reset) begin
      n = '0;
    end else if (req) begin
      n = '0;
      n.pc = 32'h4180;
    end else if (hold) begin
      if (wb_a3 != 5'd0 && wb_a3 == m.rs) n.rs_data = wb_wd;
      if (wb_a3 != 5'd0 && wb_a3 == m.rt) n.rt_data = wb_wd;
    end else if (bubble) begin
      n = '0;
      n.pc = bus.id_pc;
      n.bd = bus.id_bd;
    end else begin
      n.pc      = bus.id_pc;
      n.instr   = bus.id_instr;
      n.rs      = bus.id_rs;
      n.rt      = bus.id_rt;
      n.a3      = bus.id_a3;
      n.rs_data = bus.id_rs_data;
      n.rt_data = bus.id_rt_data;
      n.imm     = bus.id_imm;
      n.ctrl    = bus.id_ctrl;
      n.tnew    = (bus.id_tnew == 2'd0) ? 2'd0 : 2'(int'(bus.id_tnew) - 1);
      n.bd      = bus.id_bd;
      n.exc     = bus.id_exc;
    end
    m = n;
    exp_q.push_back(n);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_v !== e) begin
        errors++;
        $display("FAIL model_cycle t=%0t act=%h exp=%h", $time, dut_v, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_id();
    bus.id_pc      = $urandom;
    bus.id_instr   = $urandom;
    bus.id_rs      = 5'($urandom_range(0, 31));
    bus.id_rt      = 5'($urandom_range(0, 31));
    bus.id_a3      = 5'($urandom_range(0, 31));
    bus.id_rs_data = $urandom;
    bus.id_rt_data = $urandom;
    bus.id_imm     = $urandom;
    bus.id_ctrl    = 16'($urandom);
    bus.id_tnew    = 2'($urandom_range(0, 3));
    bus.id_bd      = 1'($urandom_range(0, 1));
    bus.id_exc     = 5'($urandom_range(0, 31));
  endtask

  // Current ID fields as they should appear in EX, with the given Tnew.
  function automatic ex_t snap(input logic [1:0] t);
    ex_t s;
    s = {bus.id_pc, bus.id_instr, bus.id_rs, bus.id_rt, bus.id_a3,
         bus.id_rs_data, bus.id_rt_data, bus.id_imm, bus.id_ctrl,
         t, bus.id_bd, bus.id_exc};
    return s;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ex_t cap;
    ex_t lit;
    rand_id();
    step();
    rand_id();
    step();
    check("reset_zero", dut_v, '0);

    reset = 1'b1;
    rand_id();
    bus.id_pc = 32'h3000;
    bus.id_tnew = 2'd2;
    step();
    check("release_pc", W'(bus.ex_pc), W'(32'h3000));
    check("release_tnew", W'(bus.ex_tnew), W'(2'd1));

    rand_id();
    bus.id_rs = 5'd8;
    bus.id_rt = 5'd3;
    bus.id_rs_data = 32'd5;
    bus.id_tnew = 2'd2;
    cap = snap(2'd1);
    step();
    check("cap_rs", W'(bus.ex_rs), W'(5'd8));
    check("cap_rs_data", W'(bus.ex_rs_data), W'(32'd5));
    hold = 1'b1;
    wb_a3 = 5'd8;
    wb_wd = 32'hDEAD;
    rand_id();
    step();
    cap.rs_data = 32'hDEAD;
    check("hold_snoop_rs", W'(bus.ex_rs_data), W'(32'hDEAD));
    check("hold_others", dut_v, cap);

    hold = 1'b0;
    wb_a3 = 5'd0;
    rand_id();
    bus.id_rs = 5'd9;
    bus.id_rt = 5'd9;
    step();
    hold = 1'b1;
    wb_a3 = 5'd9;
    wb_wd = 32'd7;
    step();
    check("hold_both_rs", W'(bus.ex_rs_data), W'(32'd7));
    check("hold_both_rt", W'(bus.ex_rt_data), W'(32'd7));

    hold = 1'b0;
    wb_a3 = 5'd0;
    rand_id();
    bus.id_rs = 5'd0;
    bus.id_rt = 5'd4;
    bus.id_rs_data = 32'h1234_5678;
    bus.id_rt_data = 32'hCAFE_0001;
    bus.id_tnew = 2'd2;
    cap = snap(2'd1);
    step();
    hold = 1'b1;
    wb_wd = 32'd7;
    rand_id();
    step();
    check("hold_a3_zero", dut_v, cap);

    hold = 1'b0;
    bubble = 1'b1;
    rand_id();
    bus.id_pc = 32'h3010;
    bus.id_bd = 1'b1;
    step();
    lit = '0;
    lit.pc = 32'h3010;
    lit.bd = 1'b1;
    check("bubble_pc", W'(bus.ex_pc), W'(32'h3010));
    check("bubble_bd", W'(bus.ex_bd), W'(1'b1));
    check("bubble_ctrl", W'(bus.ex_ctrl), '0);
    check("bubble_all", dut_v, lit);

    bubble = 1'b0;
    rand_id();
    step();
    hold = 1'b1;
    req = 1'b1;
    rand_id();
    step();
    lit = '0;
    lit.pc = 32'h4180;
    check("req_over_hold", dut_v, lit);

    req = 1'b0;
    hold = 1'b0;
    rand_id();
    bus.id_tnew = 2'd3;
    cap = snap(2'd2);
    step();
    hold = 1'b1;
    bubble = 1'b1;
    wb_a3 = 5'd0;
    rand_id();
    step();
    check("hold_over_bubble", dut_v, cap);

    hold = 1'b0;
    bubble = 1'b0;
    rand_id();
    bus.id_tnew = 2'd0;
    step();
    check("tnew_zero", W'(bus.ex_tnew), '0);
    rand_id();
    bus.id_tnew = 2'd3;
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      check("tnew_frozen", W'(bus.ex_tnew), W'(2'd2));
    end

    // Random traffic; WB address biased toward the held operands to exercise snoop.
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      req    = ($urandom_range(0, 99) < 4);
      hold   = ($urandom_range(0, 99) < 35);
      bubble = ($urandom_range(0, 99) < 20);
      rand_id();
      case ($urandom_range(0, 3))
        0:       wb_a3 = m.rs;
        1:       wb_a3 = m.rt;
        default: wb_a3 = 5'($urandom_range(0, 31));
      endcase
      wb_wd = $urandom;
      step();
    end

    reset = 1'b1;
    req = 1'b0;
    hold = 1'b0;
    bubble = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
